dmem_ctrl: RTL and testbench

//  Memory-stage load/store unit between the pipelined datapath's M stage and an external

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl_lsu_align.sv | 70 +++++++
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 access codes,
// FSM state encoding and byte-enable constants.
package dmem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Variable-latency data bus between the load/store unit (master) and memory (slave).
// Request is held until a single-cycle ack; read data is valid in the ack cycle.
interface dmem_ctrl_if;

  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWdata;
  logic [3:0]  BusBe;
  logic        BusAck;
  logic [31:0] BusRdata;

  modport master (
    output BusReq, BusWe, BusAddr, BusWdata, BusBe,
    input  BusAck, BusRdata
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWdata, BusBe,
    output BusAck, BusRdata
  );

endinterface

// File: rtl/dmem_ctrl_lsu_align.sv
// Combinational lane steering: byte enables, replicated store data, extended load data
// and the misaligned/illegal-access flag from addr[1:0] and funct3. Zero latency.
module dmem_ctrl_lsu_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        bad_f3;
  logic        unaligned;

  always_comb begin
    byte_v = rdata[7:0];
    case (lane)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = BE_ALL;
    wdata_rep = wdata;
    rdata_ext = rdata;
    bad_f3    = 1'b0;
    unaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        be        = BE_BYTE0 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_v[7]}}, byte_v};
      end
      F3_LH: begin
        unaligned = lane[0];
        be        = lane[1] ? BE_HI_HALF : BE_LO_HALF;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_v[15]}}, half_v};
      end
      F3_LW: begin
        unaligned = |lane;
      end
      F3_LBU: begin
        bad_f3    = is_store;
        rdata_ext = {24'd0, byte_v};
      end
      F3_LHU: begin
        bad_f3    = is_store;
        unaligned = lane[0];
        rdata_ext = {16'd0, half_v};
      end
      default: bad_f3 = 1'b1;
    endcase
    // Loads always fetch the whole word; lane selection happens on the way back.
    if (!is_store) be = BE_ALL;
    misalign = bad_f3 | unaligned;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage load/store unit: IDLE/BUSY/DONE FSM over a req/ack bus, k BUSY cycles -> k+2 latency.
// Stalls the pipeline while an access is outstanding; abandons the access after TIMEOUT BUSY cycles.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MisalignM,
  output logic        BusErrM,
  dmem_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        in_idle;
  logic [1:0]  al_lane;
  logic [2:0]  al_funct3;
  logic        al_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  // While idle the aligner looks at the live M-stage operands; afterwards at the latched copy.
  assign in_idle   = (state_q == ST_IDLE);
  assign al_lane   = in_idle ? ALUResultM[1:0] : lane_q;
  assign al_funct3 = in_idle ? funct3M : funct3_q;
  assign al_store  = in_idle ? MemWriteM : bus_we_q;

  dmem_ctrl_lsu_align u_align (
    .lane      (al_lane),
    .funct3    (al_funct3),
    .is_store  (al_store),
    .wdata     (WriteDataM),
    .rdata     (bus.BusRdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    StallMem    = 1'b0;
    MisalignM   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MemReadM || MemWriteM) begin
          if (al_misalign) begin
            MisalignM = 1'b1;
          end else begin
            StallMem    = 1'b1;
            state_d     = ST_BUSY;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = MemWriteM;
            bus_addr_d  = {ALUResultM[31:2], 2'b00};
            bus_wdata_d = al_wdata;
            bus_be_d    = al_be;
            funct3_d    = funct3M;
            lane_d      = ALUResultM[1:0];
            rdata_d     = '0;
            err_d       = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        StallMem = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (bus.BusAck) begin
          bus_req_d = 1'b0;
          rdata_d   = bus_we_q ? 32'd0 : al_rdata;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.BusReq   = bus_req_q;
  assign bus.BusWe    = bus_we_q;
  assign bus.BusAddr  = bus_addr_q;
  assign bus.BusWdata = bus_wdata_q;
  assign bus.BusBe    = bus_be_q;

  assign ReadDataM = (state_q == ST_DONE) ? rdata_q : 32'd0;
  assign BusErrM   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT=4; a scripted bus slave acks after a chosen
// number of BUSY cycles (0 = never) and each access reports stall/request counts and results.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        MisalignM;
  logic        BusErrM;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          r_stall;
  int          r_req;
  logic [31:0] r_rd;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic        r_unstable;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the controller idle.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdat);
    bit done;
    int busy;
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    done       = 1'b0;
    busy       = 0;
    r_stall    = 0;
    r_req      = 0;
    r_unstable = 1'b0;
    r_rd       = 32'hxxxxxxxx;
    r_err      = 1'bx;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (StallMem) r_stall++;
      if (bus.BusReq) begin
        busy++;
        r_req++;
        if (busy == 1) begin
          r_addr  = bus.BusAddr;
          r_wdata = bus.BusWdata;
          r_be    = bus.BusBe;
          r_we    = bus.BusWe;
        end else if (r_addr !== bus.BusAddr || r_wdata !== bus.BusWdata ||
                     r_be !== bus.BusBe || r_we !== bus.BusWe) begin
          r_unstable = 1'b1;
        end
        bus.BusAck   = (busy == ack_at);
        bus.BusRdata = rdat;
      end else if (c > 0 && !StallMem) begin
        r_rd      = ReadDataM;
        r_err     = BusErrM;
        done      = 1'b1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.BusAck = 1'b0;
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
  endtask

  initial begin
    reset        = 1'b0;
    MemReadM     = 1'b0;
    MemWriteM    = 1'b0;
    funct3M      = 3'b000;
    ALUResultM   = 32'd0;
    WriteDataM   = 32'd0;
    bus.BusAck   = 1'b0;
    bus.BusRdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, bus.BusReq}, 32'd0);
    chk("rst_stall", {31'd0, StallMem},   32'd0);
    chk("rst_rdata", ReadDataM,           32'd0);
    chk("rst_err",   {31'd0, BusErrM},    32'd0);
    chk("rst_addr",  bus.BusAddr,         32'd0);
    chk("rst_be",    {28'd0, bus.BusBe},  32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // LW, ack on first BUSY cycle
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1, 32'hDEADBEEF);
    chk("lw_stall", r_stall, 2);
    chk("lw_req",   r_req, 1);
    chk("lw_rdata", r_rd, 32'hDEADBEEF);
    chk("lw_err",   {31'd0, r_err}, 32'd0);
    chk("lw_addr",  r_addr, 32'h100);
    chk("lw_be",    {28'd0, r_be}, 32'hF);
    chk("lw_we",    {31'd0, r_we}, 32'd0);

    // Sub-word loads, ack after 2 BUSY cycles
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 2, 32'h80FF0000);
    chk("lb_rdata",  r_rd, 32'hFFFFFF80);
    chk("lb_stall",  r_stall, 3);
    chk("lb_addr",   r_addr, 32'h100);
    chk("lb_stable", {31'd0, r_unstable}, 32'd0);
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h80FF0000);
    chk("lbu_rdata", r_rd, 32'h00000080);
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 1, 32'h80FF0000);
    chk("lh_rdata",  r_rd, 32'hFFFF80FF);
    run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 1, 32'h80FF0000);
    chk("lhu_rdata", r_rd, 32'h000080FF);
    run_access(1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 1, 32'h12347F56);
    chk("lb1_rdata", r_rd, 32'h0000007F);

    // Stores
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'hFFFFFFFF);
    chk("sh_be",     {28'd0, r_be}, 32'hC);
    chk("sh_wdata",  r_wdata, 32'hABCDABCD);
    chk("sh_we",     {31'd0, r_we}, 32'd1);
    chk("sh_addr",   r_addr, 32'h200);
    chk("sh_rdata",  r_rd, 32'd0);
    chk("sh_stable", {31'd0, r_unstable}, 32'd0);
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 32'd0);
    chk("sb_be",     {28'd0, r_be}, 32'h2);
    chk("sb_wdata",  r_wdata, 32'hA5A5A5A5);
    run_access(1'b1, 1'b1, 3'b010, 32'h30C, 32'hCAFEF00D, 1, 32'h11111111);
    chk("rw_we",     {31'd0, r_we}, 32'd1);
    chk("rw_wdata",  r_wdata, 32'hCAFEF00D);
    chk("rw_be",     {28'd0, r_be}, 32'hF);
    chk("rw_rdata",  r_rd, 32'd0);

    // Misaligned LW and illegal store funct3
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h101;
    #1;
    chk("mis_pulse", {31'd0, MisalignM}, 32'd1);
    chk("mis_stall", {31'd0, StallMem},  32'd0);
    @(posedge clk);
    #1;
    chk("mis_req",   {31'd0, bus.BusReq}, 32'd0);
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    funct3M    = 3'b100;
    ALUResultM = 32'h200;
    #1;
    chk("ill_pulse", {31'd0, MisalignM}, 32'd1);
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    #1;
    chk("mis_clear", {31'd0, MisalignM}, 32'd0);
    chk("mis_req2",  {31'd0, bus.BusReq}, 32'd0);

    // Ack while idle must be ignored
    bus.BusAck   = 1'b1;
    bus.BusRdata = 32'h55555555;
    @(posedge clk);
    #1;
    bus.BusAck = 1'b0;
    #1;
    chk("idle_ack_stall", {31'd0, StallMem}, 32'd0);
    chk("idle_ack_rdata", ReadDataM, 32'd0);

    // Timeout: no ack
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 0, 32'h99999999);
    chk("to_req",   r_req, 4);
    chk("to_stall", r_stall, 5);
    chk("to_err",   {31'd0, r_err}, 32'd1);
    chk("to_rdata", r_rd, 32'd0);
    #1;
    chk("to_err_pulse", {31'd0, BusErrM}, 32'd0);

    // Reset while BUSY with ack pending
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h500;
    @(posedge clk);
    #1;
    chk("rb_req_busy", {31'd0, bus.BusReq}, 32'd1);
    reset        = 1'b0;
    MemReadM     = 1'b0;
    bus.BusAck   = 1'b1;
    bus.BusRdata = 32'h77777777;
    #1;
    chk("rb_req",   {31'd0, bus.BusReq}, 32'd0);
    chk("rb_stall", {31'd0, StallMem},   32'd0);
    @(posedge clk);
    #1;
    bus.BusAck = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 1, 32'h12345678);
    chk("post_rst_rdata", r_rd, 32'h12345678);
    chk("post_rst_stall", r_stall, 2);
    chk("post_rst_addr",  r_addr, 32'h300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
